// File: rtl/uart_rx_fifo.sv
// UART receiver with first-word-fall-through receive FIFO; define UART_RX_MAJORITY_EN for 2-of-3 sample voting.
// Word visible 1 Clk after the last stop sample; RxReady pops the head, a push into a full FIFO is dropped and flagged.

module uart_rx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic [AW:0]      level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign pop_vld  = (level_q != '0);
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign push_rdy = (level_q != FULL_LVL) || pop_rdy;
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;
  assign pop_dat  = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge core_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic [DIV_WIDTH-1:0]        BaudDiv,
  input  logic                        ParityEn,
  input  logic                        ParityOdd,
  input  logic                        StopBits2,
  input  logic                        RxD,
  input  logic                        RxReady,
  output logic                        RxValid,
  output logic [DATA_BITS-1:0]        RxData,
  output logic                        RxFrameErr,
  output logic                        RxParErr,
  output logic                        RxBreak,
  output logic                        OverrunErr,
  input  logic                        ErrClr,
  output logic [$clog2(FIFO_DEPTH):0] FifoLevel
);
  localparam int BCW = $clog2(OVERSAMPLE);
  localparam int DCW = $clog2(DATA_BITS + 1);
  localparam int EW  = DATA_BITS + 3;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] SMP_MID  = BCW'(OVERSAMPLE / 2);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [BCW-1:0] SMP_PRE  = BCW'(OVERSAMPLE / 2 - 1);
  localparam logic [BCW-1:0] SMP_DEC  = BCW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [BCW-1:0] SMP_DEC  = SMP_MID;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAITHI} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [DIV_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]         bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   par_bit_q, par_bit_d;
  logic                   frame_err_q, frame_err_d;
  logic                   par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic                   overrun_q, overrun_d;
  logic                   rxs, tick, smp_now, bit_end, smp_val;
  logic                   fe_now, par_err, brk;
  logic                   push_vld, push_rdy, pop_vld;
  logic [EW-1:0]          push_dat, pop_dat;

  assign rxs     = sync_q[1];
  assign tick    = (tick_cnt_q == '0);
  assign smp_now = tick && (bit_cnt_q == SMP_DEC);
  assign bit_end = tick && (bit_cnt_q == BIT_LAST);

  always_comb begin
    sync_d     = {sync_q[0], RxD};
    tick_cnt_d = tick ? BaudDiv : tick_cnt_q - DIV_WIDTH'(1);
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (tick && bit_cnt_q == SMP_PRE) vote_d[0] = rxs;
    if (tick && bit_cnt_q == SMP_MID) vote_d[1] = rxs;
    smp_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) vote_q <= 2'b11;
    else        vote_q <= vote_d;
  end
`else
  assign smp_val = rxs;
`endif

  // Word flags include the stop sample being taken in the push cycle.
  assign fe_now   = frame_err_q | ~smp_val;
  assign par_err  = par_en_q & ((^data_q ^ par_bit_q) != par_odd_q);
  assign brk      = fe_now & (data_q == '0) & (~par_en_q | ~par_bit_q);
  assign push_dat = {brk, par_err, fe_now, data_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    data_d      = data_q;
    par_bit_d   = par_bit_q;
    frame_err_d = frame_err_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    push_vld    = 1'b0;

    if (tick && state_q != S_IDLE && state_q != S_WAITHI)
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BCW'(1);

    case (state_q)
      S_IDLE: begin
        if (tick && !rxs) begin
          state_d     = S_START;
          bit_cnt_d   = '0;
          bit_idx_d   = '0;
          stop_idx_d  = 1'b0;
          par_bit_d   = 1'b0;
          frame_err_d = 1'b0;
          par_en_d    = ParityEn;
          par_odd_d   = ParityOdd;
          stop2_d     = StopBits2;
        end
      end
      S_START: begin
        if (smp_now && smp_val) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (smp_now) begin
          data_d    = {smp_val, data_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + DCW'(1);
        end
        if (bit_end && bit_idx_q == DCW'(DATA_BITS))
          state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (smp_now) par_bit_d = smp_val;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (smp_now) begin
          if (!smp_val) frame_err_d = 1'b1;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            push_vld  = 1'b1;
            bit_cnt_d = '0;
            state_d   = rxs ? S_IDLE : S_WAITHI;
          end
        end
      end
      S_WAITHI: begin
        // A held-low line must return high before another start is accepted.
        if (tick && rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (ErrClr) overrun_d = 1'b0;
    if (push_vld && !push_rdy) overrun_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      frame_err_q <= frame_err_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo_buf #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .core_clk (Clk),
    .arst_n   (Rst_n),
    .push_vld (push_vld),
    .push_rdy (push_rdy),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .pop_rdy  (RxReady),
    .pop_dat  (pop_dat),
    .level    (FifoLevel)
  );

  assign RxValid    = pop_vld;
  assign OverrunErr = overrun_q;
  assign {RxBreak, RxParErr, RxFrameErr, RxData} = pop_vld ? pop_dat : '0;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames built from bit lists, expected words from a queue model of the frame rules.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  localparam int OS    = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int SMP = OS / 2 + 1;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int SMP = OS / 2;
  localparam logic [7:0] GLITCH_EXP = 8'hF7;
`endif
  // synchroniser (2) + start detect (1) + 9 bits before stop + stop sample offset + FIFO register (1)
  localparam int LAT = 2 + 1 + 9 * OS + SMP + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       brk;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n, ParityEn, ParityOdd, StopBits2, RxD, RxReady, ErrClr;
  logic [15:0] BaudDiv;
  logic        RxValid, RxFrameErr, RxParErr, RxBreak, OverrunErr;
  logic [7:0]  RxData;
  logic [3:0]  FifoLevel;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = -1;
  logic vld_prev = 1'b0;
  exp_t exp_q[$];
  logic model_ovr = 1'b0;

  uart_rx_fifo dut (
    .Clk(Clk), .Rst_n(Rst_n), .BaudDiv(BaudDiv), .ParityEn(ParityEn),
    .ParityOdd(ParityOdd), .StopBits2(StopBits2), .RxD(RxD), .RxReady(RxReady),
    .RxValid(RxValid), .RxData(RxData), .RxFrameErr(RxFrameErr), .RxParErr(RxParErr),
    .RxBreak(RxBreak), .OverrunErr(OverrunErr), .ErrClr(ErrClr), .FifoLevel(FifoLevel)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (RxValid === 1'b1 && vld_prev !== 1'b1 && rise_cyc < 0) rise_cyc = cyc;
    vld_prev = RxValid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_n(input logic v, input int n);
    RxD = v;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    drive_n(v, OS * (int'(BaudDiv) + 1));
  endtask

  task automatic model_push(input exp_t e);
    if (exp_q.size() == DEPTH) model_ovr = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic [1:0] stop_bad);
    exp_t e;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (ParityEn) drive_bit(pbit);
    drive_bit(~stop_bad[0]);
    if (StopBits2) drive_bit(~stop_bad[1]);
    drive_bit(1'b1);
    drive_bit(1'b1);
    e.d   = d;
    e.fe  = stop_bad[0] | (StopBits2 & stop_bad[1]);
    e.pe  = ParityEn && ((^d ^ pbit) != ParityOdd);
    e.brk = e.fe && (d == 8'h00) && (!ParityEn || !pbit);
    model_push(e);
  endtask

  task automatic drain();
    exp_t e;
    check("level_before_read", FifoLevel, exp_q.size());
    check("overrun_flag", OverrunErr, model_ovr);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid", RxValid, 1);
      check("data", RxData, e.d);
      check("frame_err", RxFrameErr, e.fe);
      check("par_err", RxParErr, e.pe);
      check("break", RxBreak, e.brk);
      RxReady = 1'b1;
      @(posedge Clk); #1;
      RxReady = 1'b0;
    end
    check("empty_valid", RxValid, 0);
    check("empty_level", FifoLevel, 0);
    ErrClr = 1'b1;
    @(posedge Clk); #1;
    ErrClr = 1'b0;
    model_ovr = 1'b0;
    check("overrun_cleared", OverrunErr, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       good;
    Rst_n = 1'b0; RxD = 1'b1; RxReady = 1'b0; ErrClr = 1'b0; BaudDiv = 16'd0;
    ParityEn = 1'b0; ParityOdd = 1'b0; StopBits2 = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_valid", RxValid, 0);
    check("rst_level", FifoLevel, 0);
    check("rst_overrun", OverrunErr, 0);
    check("rst_data", RxData, 0);
    check("rst_flags", {RxFrameErr, RxParErr, RxBreak}, 0);
    Rst_n = 1'b1;
    drive_n(1'b1, 20);

    // 8N1 0xA5 with latency
    send_frame(8'hA5, 1'b0, 2'b00);
    check("latency", rise_cyc - start_cyc, LAT);
    check("level_one", FifoLevel, 1);
    drain();

    // 8E1 / 8O1 parity
    ParityEn = 1'b1;
    send_frame(8'h03, 1'b1, 2'b00);
    send_frame(8'h03, 1'b0, 2'b00);
    ParityOdd = 1'b1;
    send_frame(8'h03, 1'b1, 2'b00);
    drain();
    ParityEn = 1'b0; ParityOdd = 1'b0;

    // break: three frame times low
    drive_n(1'b0, 3 * 10 * OS);
    drive_n(1'b1, 4 * OS);
    model_push('{d: 8'h00, fe: 1'b1, pe: 1'b0, brk: 1'b1});
    drain();

    // false start then a good frame
    drive_n(1'b0, 4);
    drive_n(1'b1, 40);
    check("false_start_valid", RxValid, 0);
    check("false_start_level", FifoLevel, 0);
    send_frame(8'h3C, 1'b0, 2'b00);
    drain();

    // overrun
    for (int v = 1; v <= 9; v++) send_frame(8'(v), 1'b0, 2'b00);
    drain();

    // one-clock glitch at data bit 3 sample point of 0xFF
    drive_n(1'b0, OS);
    drive_n(1'b1, 3 * OS);
    drive_n(1'b1, 9);
    drive_n(1'b0, 1);
    drive_n(1'b1, OS - 10);
    drive_n(1'b1, 4 * OS);
    drive_n(1'b1, 3 * OS);
    model_push('{d: GLITCH_EXP, fe: 1'b0, pe: 1'b0, brk: 1'b0});
    drain();

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      BaudDiv   = 16'($urandom_range(0, 2));
      ParityEn  = 1'($urandom_range(0, 1));
      ParityOdd = 1'($urandom_range(0, 1));
      StopBits2 = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      good = ^d ^ ParityOdd;
      send_frame(d, ($urandom_range(0, 3) == 0) ? ~good : good,
                 ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      if ($urandom_range(0, 5) == 0 || i == 23) drain();
    end

    // reset mid-frame empties FIFO and aborts the frame
    BaudDiv = 16'd0; ParityEn = 1'b0; StopBits2 = 1'b0;
    drive_n(1'b1, 3 * OS);
    send_frame(8'h11, 1'b0, 2'b00);
    drive_n(1'b0, 40);
    Rst_n = 1'b0;
    RxD = 1'b1;
    #2;
    check("midrst_valid", RxValid, 0);
    check("midrst_level", FifoLevel, 0);
    exp_q.delete();
    model_ovr = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    drive_n(1'b1, 2 * OS);
    send_frame(8'h5A, 1'b0, 2'b00);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
